// File: rtl/tv80_rmw_pkg.sv
// tv80_rmw_pkg: shared state encoding and constants for the indexed CB-group
// read-modify-write engine.
package tv80_rmw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_READ,
        ST_EXEC,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam logic [1:0] GRP_ROT = 2'b00;
    localparam logic [1:0] GRP_BIT = 2'b01;
    localparam logic [1:0] GRP_RES = 2'b10;
    localparam logic [1:0] GRP_SET = 2'b11;

    localparam logic [2:0] ROT_RLC = 3'd0;
    localparam logic [2:0] ROT_RRC = 3'd1;
    localparam logic [2:0] ROT_RL  = 3'd2;
    localparam logic [2:0] ROT_RR  = 3'd3;
    localparam logic [2:0] ROT_SLA = 3'd4;
    localparam logic [2:0] ROT_SRA = 3'd5;
    localparam logic [2:0] ROT_SLL = 3'd6;
    localparam logic [2:0] ROT_SRL = 3'd7;

    localparam int FLAG_S = 7;
    localparam int FLAG_Z = 6;
    localparam int FLAG_Y = 5;
    localparam int FLAG_H = 4;
    localparam int FLAG_X = 3;
    localparam int FLAG_P = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 0;

    localparam logic [2:0] REG_MEM = 3'b110;

endpackage

// File: rtl/tv80_rmw_bitop_if.sv
// tv80_rmw_bitop_if: memory bus between the RMW engine (master) and memory (slave).
interface tv80_rmw_bitop_if #(
    parameter int DW = 8,
    parameter int AW = 16
);
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (output mem_addr, mem_rd, mem_wr, mem_wdata, input mem_rdata, mem_ack);
    modport slave  (input mem_addr, mem_rd, mem_wr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/tv80_rmw_alu.sv
// tv80_rmw_alu: combinational CB-group shift/rotate, BIT, RES and SET with Z80 flags.
module tv80_rmw_alu
    import tv80_rmw_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [1:0]    grp,
    input  logic [2:0]    n,
    input  logic [DW-1:0] data,
    input  logic [7:0]    flags_in,
    input  logic [1:0]    ea_yx,
    output logic [DW-1:0] result,
    output logic [7:0]    flags
);
    logic [DW-1:0] rot;
    logic [DW-1:0] mask;
    logic          co;
    logic          bit_v;

    always_comb begin
        co = n[0] ? data[0] : data[DW-1];
        case (n)
            ROT_RLC: rot = {data[DW-2:0], data[DW-1]};
            ROT_RRC: rot = {data[0], data[DW-1:1]};
            ROT_RL:  rot = {data[DW-2:0], flags_in[FLAG_C]};
            ROT_RR:  rot = {flags_in[FLAG_C], data[DW-1:1]};
            ROT_SLA: rot = {data[DW-2:0], 1'b0};
            ROT_SRA: rot = {data[DW-1], data[DW-1:1]};
            ROT_SLL: rot = {data[DW-2:0], 1'b1};
            default: rot = {1'b0, data[DW-1:1]};
        endcase
    end

    assign mask  = DW'(1) << n;
    assign bit_v = |(data & mask);

    // Flag vectors are S Z Y H X P N C; BIT takes Y/X from the high address byte.
    assign result = grp == GRP_ROT ? rot
                  : grp == GRP_RES ? data & ~mask
                  : grp == GRP_SET ? data | mask
                  : data;
    assign flags  = grp == GRP_ROT ? {rot[DW-1], ~|rot, rot[5], 1'b0, rot[3], ~^rot, 1'b0, co}
                  : grp == GRP_BIT ? {n == 3'd7 && bit_v, ~bit_v, ea_yx[1], 1'b1, ea_yx[0], ~bit_v, 1'b0, flags_in[FLAG_C]}
                  : flags_in;
endmodule

// File: rtl/tv80_rmw_bitop.sv
// tv80_rmw_bitop: (IX/IY+d) CB-group read-modify-write engine with bus timeout.
// Define TV80_RMW_REGCOPY_EN to generate the undocumented register copy strobe.
module tv80_rmw_bitop
    import tv80_rmw_pkg::*;
#(
    parameter int DW       = 8,
    parameter int AW       = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [7:0]          op,
    input  logic [AW-1:0]       base,
    input  logic [7:0]          disp,
    input  logic [7:0]          flags_in,
    tv80_rmw_bitop_if.master    bus,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [DW-1:0]       result,
    output logic [7:0]          flags_out,
    output logic                reg_wr_en,
    output logic [2:0]          reg_sel
);
    localparam int CW = $clog2(WAIT_MAX + 1);

    state_t        state, nxt;
    logic [7:0]    op_q;
    logic [AW-1:0] base_q;
    logic [7:0]    disp_q;
    logic [7:0]    flags_q;
    logic [AW-1:0] ea;
    logic [DW-1:0] data_q;
    logic [CW-1:0] cnt;
    logic          timeout;
    logic [DW-1:0] alu_result;
    logic [7:0]    alu_flags;

    assign timeout = !bus.mem_ack && cnt == CW'(WAIT_MAX - 1);

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  nxt = start ? ST_ADDR : ST_IDLE;
            ST_ADDR:  nxt = ST_READ;
            ST_READ:  nxt = bus.mem_ack ? ST_EXEC : timeout ? ST_IDLE : ST_READ;
            ST_EXEC:  nxt = op_q[7:6] == GRP_BIT ? ST_DONE : ST_WRITE;
            ST_WRITE: nxt = bus.mem_ack ? ST_DONE : timeout ? ST_IDLE : ST_WRITE;
            default:  nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            base_q    <= '0;
            disp_q    <= '0;
            flags_q   <= '0;
            ea        <= '0;
            data_q    <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            result    <= '0;
            flags_out <= '0;
        end else begin
            state <= nxt;
            cnt   <= nxt != state ? '0 : cnt + 1'b1;
            err   <= (state == ST_READ || state == ST_WRITE) && timeout;
            if (state == ST_IDLE && start) begin
                op_q    <= op;
                base_q  <= base;
                disp_q  <= disp;
                flags_q <= flags_in;
            end
            if (state == ST_ADDR) ea <= base_q + {{(AW-8){disp_q[7]}}, disp_q};
            if (state == ST_READ && bus.mem_ack) data_q <= bus.mem_rdata;
            if (state == ST_EXEC) begin
                result    <= alu_result;
                flags_out <= alu_flags;
            end
        end
    end

    tv80_rmw_alu #(.DW(DW)) u_alu (
        .grp      (op_q[7:6]),
        .n        (op_q[5:3]),
        .data     (data_q),
        .flags_in (flags_q),
        .ea_yx    ({ea[AW-3], ea[AW-5]}),
        .result   (alu_result),
        .flags    (alu_flags)
    );

    assign busy          = state != ST_IDLE;
    assign done          = state == ST_DONE;
    assign bus.mem_rd    = state == ST_READ;
    assign bus.mem_wr    = state == ST_WRITE;
    assign bus.mem_addr  = ea;
    assign bus.mem_wdata = result;

`ifdef TV80_RMW_REGCOPY_EN
    assign reg_wr_en = done && op_q[7:6] != GRP_BIT && op_q[2:0] != REG_MEM;
    assign reg_sel   = done ? op_q[2:0] : 3'd0;
`else
    logic unused_sel;
    assign unused_sel = ^op_q[2:0];
    assign reg_wr_en  = 1'b0;
    assign reg_sel    = 3'd0;
`endif
endmodule
